// File: rtl/letter_pkg.sv
// Shared constants, types and the divider-free mod-26 helper for the letter picker.
// Turns a raw generator byte into a candidate letter index plus its acceptance range flag.
package letter_pkg;

  localparam int unsigned LETTER_COUNT = 26;
  localparam logic [7:0]  ACCEPT_LIMIT = 8'd234;
  localparam logic [7:0]  ASCII_A      = 8'h41;

  typedef logic [4:0] letter_idx_t;

  localparam letter_idx_t NONE_IDX = 5'd31;

  typedef struct packed {
    logic        in_range;
    letter_idx_t idx;
  } candidate_t;

  // Greedy subtraction of 26*k, largest multiple first, leaves a remainder below 26.
  function automatic letter_idx_t mod26(input logic [7:0] value);
    logic [7:0] rem;
    rem = value;
    for (int k = 8; k >= 1; k--) begin
      if (rem >= 8'(LETTER_COUNT * k)) begin
        rem = rem - 8'(LETTER_COUNT * k);
      end
    end
    return letter_idx_t'(rem);
  endfunction

  function automatic candidate_t make_candidate(input logic [7:0] value);
    candidate_t cand;
    cand.in_range = (value < ACCEPT_LIMIT);
    cand.idx      = mod26(value);
    return cand;
  endfunction

endpackage

// File: rtl/letter_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always presented on rdata_o while valid_o is high.
// Push and pop may occur together; a push into a full FIFO is only taken alongside a pop.
module letter_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CountW = $clog2(Depth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [Width-1:0]  wdata_i,
  output logic [Width-1:0]  rdata_o,
  output logic              valid_o,
  output logic [CountW-1:0] count_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              push, pop;

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    pop      = pop_i && valid_o;
    push     = push_i && ((count_q < CountW'(Depth)) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointer overflow is the wrap.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CountW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/letter_picker.sv
// Rejection-samples generator bytes into uniform letters A-Z, optionally dropping back-to-back
// repeats, and buffers accepted letters in a show-ahead FIFO behind a valid/ready handshake.
module letter_picker
  import letter_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NO_REPEAT = 1,
  localparam int unsigned CountW   = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        rand_byte_i,
  input  logic              letter_ready_i,
  output logic              letter_valid_o,
  output logic [4:0]        letter_o,
  output logic [7:0]        letter_ascii_o,
  output logic [CountW-1:0] fill_count_o,
  output logic [15:0]       reject_count_o
);

  candidate_t  cand;
  letter_idx_t last_q, last_d;
  logic [15:0] reject_q, reject_d;
  logic        is_repeat, accept, space, pop, push, reject;

  always_comb begin
    cand      = make_candidate(rand_byte_i);
    is_repeat = (NO_REPEAT != 0) && (cand.idx == last_q);
    accept    = cand.in_range && !is_repeat;
    pop       = letter_valid_o && letter_ready_i;
    space     = (fill_count_o < CountW'(DEPTH)) || pop;
    push      = space && accept;
    // Cycles lost to a full FIFO are not rejections.
    reject    = space && !accept;

    last_d   = push ? cand.idx : last_q;
    reject_d = reject_q;
    if (reject && (reject_q != 16'hFFFF)) begin
      reject_d = reject_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q   <= NONE_IDX;
      reject_q <= '0;
    end else begin
      last_q   <= last_d;
      reject_q <= reject_d;
    end
  end

  letter_fifo #(
    .Width (5),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cand.idx),
    .rdata_o (letter_o),
    .valid_o (letter_valid_o),
    .count_o (fill_count_o)
  );

  assign letter_ascii_o = ASCII_A + {3'b000, letter_o};
  assign reject_count_o = reject_q;

endmodule

// File: tb/tb_letter_picker.sv
// Bench for letter_picker: directed scenarios plus randomized traffic against a queue model,
// run on a NO_REPEAT=1 instance (index 0) and a NO_REPEAT=0 instance (index 1) fed identically.
module tb_letter_picker;

  localparam int unsigned DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rand_byte = 8'd0;
  logic          letter_ready = 1'b0;
  logic          v [2];
  logic [4:0]    l [2];
  logic [7:0]    a [2];
  logic [CW-1:0] f [2];
  logic [15:0]   r [2];

  int checks = 0;
  int errors = 0;

  // Reference model: queue of letter indices, last pushed index (-1 = none), reject tally.
  int mq [2][$];
  int mlast [2];
  int mrej [2];
  int nr [2] = '{1, 0};

  always #5 clk = ~clk;

  letter_picker #(.DEPTH(DEPTH), .NO_REPEAT(1)) u_dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .rand_byte_i    (rand_byte),
    .letter_ready_i (letter_ready),
    .letter_valid_o (v[0]),
    .letter_o       (l[0]),
    .letter_ascii_o (a[0]),
    .fill_count_o   (f[0]),
    .reject_count_o (r[0])
  );

  letter_picker #(.DEPTH(DEPTH), .NO_REPEAT(0)) u_dut_nr (
    .clk_i          (clk),
    .reset_i        (reset),
    .rand_byte_i    (rand_byte),
    .letter_ready_i (letter_ready),
    .letter_valid_o (v[1]),
    .letter_o       (l[1]),
    .letter_ascii_o (a[1]),
    .fill_count_o   (f[1]),
    .reject_count_o (r[1])
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mlast[i] = -1;
      mrej[i]  = 0;
    end
  endtask

  // Apply one candidate for one clock; the model follows the letter rules directly.
  task automatic step(input logic [7:0] b, input logic rdy);
    int bi;
    bi = int'(b);
    rand_byte    = b;
    letter_ready = rdy;
    for (int i = 0; i < 2; i++) begin
      bit pop, space, ok;
      pop   = (mq[i].size() > 0) && rdy;
      space = (mq[i].size() < DEPTH) || pop;
      ok    = (bi < 234) && !(nr[i] == 1 && (bi % 26) == mlast[i]);
      if (pop) void'(mq[i].pop_front());
      if (space && ok) begin
        mq[i].push_back(bi % 26);
        mlast[i] = bi % 26;
      end else if (space && mrej[i] < 65535) begin
        mrej[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", v[0]); end
    checks++; if (l[0] !== 5'd0) begin errors++; $display("FAIL reset_letter: got %0d want 0", l[0]); end
    checks++; if (a[0] !== 8'h41) begin errors++; $display("FAIL reset_ascii: got %h want 41", a[0]); end
    checks++; if (f[0] !== '0) begin errors++; $display("FAIL reset_fill: got %0d want 0", f[0]); end
    checks++; if (r[0] !== 16'd0) begin errors++; $display("FAIL reset_rej: got %0d want 0", r[0]); end
  endtask

  task automatic test_basic();
    do_reset();
    step(8'd0, 1'b1);
    checks++; if (v[0] !== 1'b1 || l[0] !== 5'd0 || a[0] !== 8'h41)
      begin errors++; $display("FAIL basic_A: got v=%0b l=%0d a=%h want 1 0 41", v[0], l[0], a[0]); end
    step(8'd27, 1'b1);
    checks++; if (l[0] !== 5'd1 || a[0] !== 8'h42 || f[0] !== 3'd1)
      begin errors++; $display("FAIL basic_B: got l=%0d a=%h f=%0d want 1 42 1", l[0], a[0], f[0]); end
    step(8'd233, 1'b1);
    checks++; if (v[0] !== 1'b1 || l[0] !== 5'd25 || a[0] !== 8'h5A)
      begin errors++; $display("FAIL basic_Z: got v=%0b l=%0d a=%h want 1 25 5a", v[0], l[0], a[0]); end
    checks++; if (r[0] !== 16'd0) begin errors++; $display("FAIL basic_rej: got %0d want 0", r[0]); end
  endtask

  task automatic test_reject();
    step(8'd234, 1'b1);
    step(8'd255, 1'b1);
    step(8'd240, 1'b1);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL rej_empty: got %0b want 0", v[0]); end
    checks++; if (r[0] !== 16'd3) begin errors++; $display("FAIL rej_count: got %0d want 3", r[0]); end
    step(8'd52, 1'b1);
    checks++; if (v[0] !== 1'b1 || l[0] !== 5'd0)
      begin errors++; $display("FAIL rej_52: got v=%0b l=%0d want 1 0", v[0], l[0]); end
  endtask

  task automatic test_no_repeat();
    do_reset();
    step(8'd3, 1'b0);
    step(8'd29, 1'b0);
    step(8'd4, 1'b0);
    checks++; if (f[0] !== 3'd2 || l[0] !== 5'd3)
      begin errors++; $display("FAIL norep_fill: got f=%0d l=%0d want 2 3", f[0], l[0]); end
    checks++; if (r[0] !== 16'd1) begin errors++; $display("FAIL norep_rej: got %0d want 1", r[0]); end
    checks++; if (f[1] !== 3'd3 || r[1] !== 16'd0)
      begin errors++; $display("FAIL rep_fill: got f=%0d r=%0d want 3 0", f[1], r[1]); end
    step(8'd250, 1'b1);
    checks++; if (f[0] !== 3'd1 || l[0] !== 5'd4)
      begin errors++; $display("FAIL norep_second: got f=%0d l=%0d want 1 4", f[0], l[0]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 6; i++) step(8'(i), 1'b0);
    checks++; if (f[0] !== 3'd4 || l[0] !== 5'd0)
      begin errors++; $display("FAIL full_fill: got f=%0d l=%0d want 4 0", f[0], l[0]); end
    checks++; if (r[0] !== 16'd0) begin errors++; $display("FAIL full_rej: got %0d want 0", r[0]); end
    for (int n = 0; n < 4; n++) begin
      step(8'd10, 1'b1);
      checks++; if (f[1] !== 3'd4)
        begin errors++; $display("FAIL full_swap%0d: got %0d want 4", n, f[1]); end
      checks++; if (f[0] !== CW'(mq[0].size()) || r[0] !== 16'(mrej[0]))
        begin errors++; $display("FAIL full_norep%0d: got f=%0d r=%0d want %0d %0d",
                                  n, f[0], r[0], mq[0].size(), mrej[0]); end
    end
    checks++; if (l[1] !== 5'd10 || a[1] !== 8'h4B)
      begin errors++; $display("FAIL full_tailK: got l=%0d a=%h want 10 4b", l[1], a[1]); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 65540; n++) step(8'd250, 1'b1);
    checks++; if (r[0] !== 16'hFFFF)
      begin errors++; $display("FAIL sat_hold: got %h want ffff", r[0]); end
    step(8'd250, 1'b1);
    checks++; if (r[1] !== 16'hFFFF)
      begin errors++; $display("FAIL sat_nowrap: got %h want ffff", r[1]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(8'd240, 1'b0);
    step(8'd1, 1'b0);
    step(8'd2, 1'b0);
    step(8'd3, 1'b0);
    checks++; if (f[0] !== 3'd3 || r[0] !== 16'd1)
      begin errors++; $display("FAIL arst_pre: got f=%0d r=%0d want 3 1", f[0], r[0]); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (v[0] !== 1'b0 || l[0] !== 5'd0 || a[0] !== 8'h41 || f[0] !== '0 || r[0] !== '0)
      begin errors++; $display("FAIL arst_mid: got v=%0b l=%0d a=%h f=%0d r=%0d want 0 0 41 0 0",
                                v[0], l[0], a[0], f[0], r[0]); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(8'd5, 1'b1);
    checks++; if (v[0] !== 1'b1 || l[0] !== 5'd5 || a[0] !== 8'h46)
      begin errors++; $display("FAIL arst_F: got v=%0b l=%0d a=%h want 1 5 46", v[0], l[0], a[0]); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0 && mlast[0] >= 0)
        b = 8'(mlast[0] + 26 * $urandom_range(0, 8));
      else
        b = 8'($urandom_range(0, 255));
      step(b, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (v[i] !== (mq[i].size() > 0) || f[i] !== CW'(mq[i].size()) || r[i] !== 16'(mrej[i]))
          begin errors++; $display("FAIL rand_state%0d n=%0d: got v=%0b f=%0d r=%0d want %0d %0d",
                                    i, n, v[i], f[i], r[i], mq[i].size(), mrej[i]); end
        if (mq[i].size() > 0) begin
          checks++;
          if (l[i] !== 5'(mq[i][0]) || a[i] !== 8'(65 + mq[i][0]))
            begin errors++; $display("FAIL rand_head%0d n=%0d: got l=%0d a=%h want %0d",
                                      i, n, l[i], a[i], mq[i][0]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_no_repeat();
    test_full();
    test_async_reset();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/letter_picker.md
# letter_picker

Consumer end of the random byte stream: samples the 8-bit output of the free-running xorshift generator every clock and turns it into a buffered stream of uniformly distributed letters A–Z for the game logic. Out-of-range bytes are discarded by rejection sampling, and an optional rule suppresses back-to-back repeats. Accepted letters are queued in a small show-ahead FIFO and delivered over a valid/ready handshake. It sits between the generator and the target-letter logic of the typing game.

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16
- NO_REPEAT, 1: 1 = reject a letter equal to the most recently pushed letter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rand_byte  in  8  generator output, treated as a new candidate every cycle
- letter_ready  in  1  consumer accepts head letter this cycle
- letter_valid  out  1  FIFO non-empty; head letter is valid
- letter  out  5  head letter index, 0..25 = A..Z
- letter_ascii  out  8  8'h41 + letter
- fill_count  out  $clog2(DEPTH)+1  entries currently held
- reject_count  out  16  saturating count of rejected candidates

## Operation
- Candidate each cycle: idx = rand_byte mod 26, valid only if rand_byte < 234 (9×26), so all 26 letters are equally likely.
- Push condition: rand_byte < 234 AND (NO_REPEAT==0 OR idx != last_idx) AND space, where space = fill_count < DEPTH OR a pop happens this cycle.
- At most one push and one pop per cycle. A push updates last_idx to idx.
- Pop: letter_valid && letter_ready, which removes the head. Ready while empty has no effect.
- reject_count increments by 1 only when space is true and the candidate fails the range or repeat check. Full-FIFO cycles are not counted. It saturates at 16'hFFFF.
- Reset values:
  - letter_valid=0, letter=0, letter_ascii=8'h41, fill_count=0, reject_count=0
  - FIFO pointers 0
  - last_idx=31, an invalid index, so the first in-range candidate is always accepted

## Timing
- Everything is registered. A candidate pushed at edge N into an empty FIFO gives letter_valid=1 and the head letter visible after edge N. Latency is 1 cycle.
- Show-ahead: letter/letter_ascii always show the head entry while letter_valid=1. They are stable until popped; the value while empty is don't-care but must not be X.
- Full with simultaneous pop and push: fill_count stays at DEPTH, head advances, new entry is written at the tail.
- Empty with a push and letter_ready=1: no pop that cycle (valid was 0). fill_count becomes 1.
- Pointers wrap modulo DEPTH. fill_count never exceeds DEPTH and never underflows.
- Reset asserted mid-stream clears FIFO, last_idx and reject_count asynchronously. The first push is possible at the first edge after deassertion.

## Structure
- Package letter_pkg:
  - LETTER_COUNT=26
  - ACCEPT_LIMIT=8'd234
  - ASCII_A=8'h41
  - NONE_IDX=5'd31
  - letter_idx_t (5-bit typedef)
- mod-26 is a combinational function in letter_pkg (subtract 26·k over k=8..1 compare chain). No divider.
- One sub-module, letter_fifo: parameterised synchronous show-ahead FIFO (push, pop, data, count) instantiated with width 5. letter_picker holds the accept logic, last_idx and reject_count.

## Test plan
- After reset, letter_ready=1, feed rand_byte 0, 27, 233 on three edges: letters 0 ('A', 8'h41), 1 ('B'), 25 ('Z', 8'h5A) emitted in order, each 1 cycle after its push; reject_count=0.
- Feed 234, 255, 240 then 52: first three rejected, reject_count=3; 52 emits letter 0.
- NO_REPEAT=1, ready=0, feed 3 then 29 (both idx 3) then 4: fill_count=2 holding 3,4; reject_count=1. With NO_REPEAT=0 the same stimulus gives fill_count=3.
- ready=0, feed 0,1,2,3,4,5 (DEPTH=4): fill_count=4 holding A,B,C,D; bytes 4,5 dropped; reject_count unchanged. Then ready=1 with rand_byte=10 each cycle and NO_REPEAT=0: a simultaneous pop and push keeps the count at 4 and tail becomes K.
- reject_count saturation: force 70000 cycles of rand_byte=250 with space: holds 16'hFFFF with no wrap.
- Assert reset asynchronously while fill_count=3, between edges: all outputs go to reset values before the next edge. After release, rand_byte=5 emits 'F' next cycle.
